sensor_conditioner: RTL and testbench
=====================================

# sensor_conditioner

Input conditioning stage between the two raw optical gate sensors and the speed measurement block. Synchronises each sensor to `clk`, debounces it with a confirm-count state machine, and produces clean levels plus single-cycle rising-edge pulses for the timing logic. It also reports rejected glitches and flags a sensor held active too long (blocked or failed).

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1200: stable cycles required to commit a level change (100 µs at 12 MHz). Must be ≥ 1.
- `STUCK_CYCLES`, default 24_000_000: cycles of committed-high level before the fault flag is raised (2 s). Must be > `DEBOUNCE_CYCLES`.
- `ACTIVE_LOW`, default 0: 1 inverts both raw inputs before synchronisation.

Ports:
- `clk` input 1: 12 MHz system clock.
- `rst` input 1: synchronous, active-high reset.
- `sensor_a_raw` input 1: asynchronous raw gate A.
- `sensor_b_raw` input 1: asynchronous raw gate B.
- `sensor_a` output 1: debounced level A, which feeds the measurement block.
- `sensor_b` output 1: debounced level B.
- `a_rise` output 1: one-cycle pulse on committed 0→1 of A.
- `b_rise` output 1: one-cycle pulse on committed 0→1 of B.
- `fault_a` output 1: A committed high ≥ `STUCK_CYCLES`.
- `fault_b` output 1: same for B.
- `glitch_count` output 8: saturating count of rejected transitions, both channels combined.

## Operation
- Per channel: optional inversion, then 2-FF synchroniser. The FSM sees only the second flop, `s2`.
- FSM states:
  - `LOW`: `s2`=1 → `CONFIRM_HIGH`, cnt=1.
  - `CONFIRM_HIGH`: `s2`=1 → cnt+1; commit to `HIGH` on the edge where cnt reaches `DEBOUNCE_CYCLES`. `s2`=0 → `LOW`, cnt cleared, glitch event.
  - `HIGH`: `s2`=0 → `CONFIRM_LOW`, cnt=1.
  - `CONFIRM_LOW`: mirror of `CONFIRM_HIGH`. `s2`=1 → `HIGH` plus glitch event. Commit → `LOW`.
- With `DEBOUNCE_CYCLES`=1, the commit happens on the same edge the FSM would otherwise enter CONFIRM. No glitch is possible in this case.
- Level output is 1 in `HIGH` and `CONFIRM_LOW`, and 0 otherwise.
- Rise pulse is asserted for exactly the cycle after the `CONFIRM_HIGH`→`HIGH` commit. The falling commit produces no pulse.
- Stuck counter: counts every cycle the level is 1 and saturates at `STUCK_CYCLES`. Fault asserts when it reaches `STUCK_CYCLES`. Fault and counter clear on the commit to `LOW`. The fault does not suppress the level.
- Glitch counter:
  - Adds the number of glitch events in a cycle (0, 1 or 2) and saturates at 255. Simultaneous A and B glitches add 2; if only one step remains before 255, the result is 255.
  - Cleared only by `rst`.
- Counter widths: `$clog2(max+1)` of the respective parameter.

## Timing
- All outputs are registered.
- Reset: all outputs 0, synchroniser flops 0 (inactive, post-inversion), FSMs in `LOW`, all counters 0.
- Latency: raw change stable before edge N is captured in s1 at N and in s2 at N+1. It is first counted at N+2, and level/pulse change after edge N+1+`DEBOUNCE_CYCLES`.
- A raw pulse shorter than `DEBOUNCE_CYCLES` cycles (as seen at `s2`) never changes the level.
- Reset mid-CONFIRM: the channel returns to `LOW` with no pulse. After reset the full confirm count restarts.
- Channels are fully independent. Simultaneous A/B commits give pulses in the same cycle.

## Structure
- `sensor_pkg`:
  - `deb_state_t` enum (`LOW`, `CONFIRM_HIGH`, `HIGH`, `CONFIRM_LOW`).
  - `CLK_HZ`=12_000_000.
  - Default `DEBOUNCE_CYCLES`/`STUCK_CYCLES` constants, shared with the measurement block.
- Sub-module `sensor_debounce`:
  - Contains one channel's inversion, synchroniser, FSM, rise pulse, stuck counter/fault, and a `glitch` event output.
  - Instantiated twice.
- Top level holds the saturating `glitch_count` adder.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `STUCK_CYCLES`=20.
- Reset: hold `rst` for 3 cycles with raw inputs toggling → all outputs 0 throughout. FSM is in `LOW` after release.
- Clean rise: `sensor_a_raw` 0→1 before edge 0 and held → `sensor_a`=1 after edge 5. `a_rise`=1 only in the cycle after edge 5. B outputs unchanged.
- Glitch: `sensor_a_raw` high for 3 cycles then low → `sensor_a` stays 0, no pulse, `glitch_count`=1. A 3-cycle low dip while high → level stays 1, `glitch_count`=2.
- Stuck: `sensor_b_raw` held high for 40 cycles → `fault_b`=1 at stuck count 20 (edge 24). On release, `fault_b` and `sensor_b` drop together 5 edges after the raw fall.
- Simultaneous glitches: 3-cycle pulses on both raw inputs at once → `glitch_count` +2. Repeating 130 times → `glitch_count`=255, held with no wrap.
- Reset mid-operation: `rst` asserted during `CONFIRM_HIGH` at cnt=3 → no `a_rise`. With raw held high after release, `sensor_a`=1 after the full 2+4-cycle latency.

Source files
------------

// File: rtl/sensor_pkg.sv
// Shared types and constants for the optical gate sensor conditioning path.
package sensor_pkg;

  typedef enum logic [1:0] {
    LOW          = 2'd0,
    CONFIRM_HIGH = 2'd1,
    HIGH         = 2'd2,
    CONFIRM_LOW  = 2'd3
  } deb_state_t;

  localparam int unsigned CLK_HZ = 12_000_000;

  // 100 us confirm window and 2 s stuck limit at CLK_HZ; also used by the measurement block.
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1200;
  localparam int unsigned STUCK_CYCLES_DEF    = 24_000_000;

  // Adds 0..2 events to an 8-bit count, clamping at 255 instead of wrapping.
  function automatic logic [7:0] sat_add8(input logic [7:0] base, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, base} + {7'b0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// One gate channel: optional inversion, 2-FF synchroniser, confirm-count debounce FSM,
// rise pulse, stuck-high fault and a per-cycle glitch event.
//
// state        | meaning
// LOW          | committed low, waiting for s2 to go high
// CONFIRM_HIGH | s2 high, counting towards a committed rise
// HIGH         | committed high, waiting for s2 to go low
// CONFIRM_LOW  | s2 low, counting towards a committed fall (level still 1)
module sensor_debounce
  import sensor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned STUCK_CYCLES    = STUCK_CYCLES_DEF,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fault,
  output logic glitch
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int STK_W = $clog2(STUCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [STK_W-1:0] STK_MAX = STK_W'(STUCK_CYCLES);

  logic             s1, s2;
  deb_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [STK_W-1:0] stuck, stuck_nxt;
  logic             commit_rise;
  logic             level_nxt;

  // Bring the (optionally inverted) raw input into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw ^ ACTIVE_LOW;
      s2 <= s1;
    end
  end

  // Debounce next-state: a commit happens on the edge the confirm count reaches the target;
  // with a target of 1 the CONFIRM states are skipped entirely.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    glitch      = 1'b0;
    commit_rise = 1'b0;
    case (state)
      LOW: begin
        if (s2) begin
          if (CNT_MAX == CNT_ONE) begin
            state_nxt   = HIGH;
            commit_rise = 1'b1;
          end else begin
            state_nxt = CONFIRM_HIGH;
            cnt_nxt   = CNT_ONE;
          end
        end
      end
      CONFIRM_HIGH: begin
        if (s2) begin
          if ((cnt + CNT_ONE) == CNT_MAX) begin
            state_nxt   = HIGH;
            cnt_nxt     = '0;
            commit_rise = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end else begin
          state_nxt = LOW;
          cnt_nxt   = '0;
          glitch    = 1'b1;
        end
      end
      HIGH: begin
        if (!s2) begin
          if (CNT_MAX == CNT_ONE) begin
            state_nxt = LOW;
          end else begin
            state_nxt = CONFIRM_LOW;
            cnt_nxt   = CNT_ONE;
          end
        end
      end
      CONFIRM_LOW: begin
        if (!s2) begin
          if ((cnt + CNT_ONE) == CNT_MAX) begin
            state_nxt = LOW;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end else begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
          glitch    = 1'b1;
        end
      end
      default: begin
        state_nxt = LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Level and stuck count follow the post-edge state so outputs can be registered directly.
  always_comb begin
    level_nxt = (state_nxt == HIGH) || (state_nxt == CONFIRM_LOW);
    if (!level_nxt) begin
      stuck_nxt = '0;
    end else if (stuck == STK_MAX) begin
      stuck_nxt = stuck;
    end else begin
      stuck_nxt = stuck + STK_W'(1);
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOW;
      cnt   <= '0;
      stuck <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fault <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      stuck <= stuck_nxt;
      level <= level_nxt;
      rise  <= commit_rise;
      fault <= (stuck_nxt == STK_MAX);
    end
  end

endmodule

// File: rtl/sensor_conditioner.sv
// Two independent debounced gate channels plus a shared saturating glitch counter.
module sensor_conditioner
  import sensor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned STUCK_CYCLES    = STUCK_CYCLES_DEF,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_a_raw,
  input  logic       sensor_b_raw,
  output logic       sensor_a,
  output logic       sensor_b,
  output logic       a_rise,
  output logic       b_rise,
  output logic       fault_a,
  output logic       fault_b,
  output logic [7:0] glitch_count
);

  logic glitch_a, glitch_b;

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .STUCK_CYCLES   (STUCK_CYCLES),
    .ACTIVE_LOW     (ACTIVE_LOW)
  ) u_deb_a (
    .clk   (clk),
    .rst   (rst),
    .raw   (sensor_a_raw),
    .level (sensor_a),
    .rise  (a_rise),
    .fault (fault_a),
    .glitch(glitch_a)
  );

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .STUCK_CYCLES   (STUCK_CYCLES),
    .ACTIVE_LOW     (ACTIVE_LOW)
  ) u_deb_b (
    .clk   (clk),
    .rst   (rst),
    .raw   (sensor_b_raw),
    .level (sensor_b),
    .rise  (b_rise),
    .fault (fault_b),
    .glitch(glitch_b)
  );

  // Accumulate rejected transitions from both channels, clamping at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_count <= '0;
    end else begin
      glitch_count <= sat_add8(glitch_count, {1'b0, glitch_a} + {1'b0, glitch_b});
    end
  end

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner with a run-length reference model checked every cycle.
module tb_sensor_conditioner;

  localparam int D = 4;
  localparam int S = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sensor_a_raw = 1'b0;
  logic       sensor_b_raw = 1'b0;
  logic       sensor_a, sensor_b, a_rise, b_rise, fault_a, fault_b;
  logic [7:0] glitch_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: sync delay line, committed level, length of the current run of
  // samples disagreeing with it, consecutive-high count, and the combined glitch total.
  int m_s1[2], m_s2[2], m_lvl[2], m_run[2], m_stk[2], m_rise[2], m_flt[2];
  int m_gc = 0;
  bit started = 1'b0;

  sensor_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .STUCK_CYCLES   (S),
    .ACTIVE_LOW     (1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sensor_a_raw(sensor_a_raw),
    .sensor_b_raw(sensor_b_raw),
    .sensor_a    (sensor_a),
    .sensor_b    (sensor_b),
    .a_rise      (a_rise),
    .b_rise      (b_rise),
    .fault_a     (fault_a),
    .fault_b     (fault_b),
    .glitch_count(glitch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance the model on every rising edge using the same input values the DUT samples.
  always @(posedge clk) begin
    int g, smp, rv;
    g = 0;
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_run[c] = 0;
        m_stk[c] = 0; m_rise[c] = 0; m_flt[c] = 0;
      end
      m_gc = 0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        rv = (c == 0) ? int'(sensor_a_raw) : int'(sensor_b_raw);
        smp = m_s2[c];
        m_s2[c] = m_s1[c];
        m_s1[c] = rv;
        m_rise[c] = 0;
        if (smp != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == D) begin
            m_lvl[c] = smp;
            m_run[c] = 0;
            m_rise[c] = smp;
          end
        end else begin
          if (m_run[c] > 0) g++;
          m_run[c] = 0;
        end
        if (m_lvl[c] == 1) m_stk[c] = (m_stk[c] < S) ? m_stk[c] + 1 : S;
        else m_stk[c] = 0;
        m_flt[c] = (m_stk[c] >= S) ? 1 : 0;
      end
      m_gc = (m_gc + g > 255) ? 255 : m_gc + g;
    end
    started = 1'b1;
  end

  // Compare all outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (started) begin
      chk("model sensor_a", int'(sensor_a), m_lvl[0]);
      chk("model sensor_b", int'(sensor_b), m_lvl[1]);
      chk("model a_rise", int'(a_rise), m_rise[0]);
      chk("model b_rise", int'(b_rise), m_rise[1]);
      chk("model fault_a", int'(fault_a), m_flt[0]);
      chk("model fault_b", int'(fault_b), m_flt[1]);
      chk("model glitch_count", int'(glitch_count), m_gc);
    end
  end

  initial begin
    // Reset held with raw inputs toggling.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sensor_a_raw = ~sensor_a_raw;
      sensor_b_raw = ~sensor_b_raw;
      chk("reset sensor_a", int'(sensor_a), 0);
      chk("reset glitch_count", int'(glitch_count), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    sensor_a_raw = 1'b0;
    sensor_b_raw = 1'b0;
    step(6);
    chk("idle sensor_a", int'(sensor_a), 0);
    chk("idle sensor_b", int'(sensor_b), 0);

    // Clean rise on A: level and pulse after edge 5.
    sensor_a_raw = 1'b1;
    step(5);
    chk("rise edge4 sensor_a", int'(sensor_a), 0);
    step(1);
    chk("rise edge5 sensor_a", int'(sensor_a), 1);
    chk("rise edge5 a_rise", int'(a_rise), 1);
    chk("rise edge5 sensor_b", int'(sensor_b), 0);
    step(1);
    chk("rise edge6 a_rise", int'(a_rise), 0);

    // 3-cycle low dip while high is rejected.
    sensor_a_raw = 1'b0;
    step(3);
    sensor_a_raw = 1'b1;
    step(6);
    chk("dip sensor_a", int'(sensor_a), 1);
    chk("dip glitch_count", int'(glitch_count), 1);

    // Commit A low, then a 3-cycle high pulse is rejected.
    sensor_a_raw = 1'b0;
    step(8);
    chk("fall sensor_a", int'(sensor_a), 0);
    sensor_a_raw = 1'b1;
    step(3);
    sensor_a_raw = 1'b0;
    step(6);
    chk("pulse sensor_a", int'(sensor_a), 0);
    chk("pulse glitch_count", int'(glitch_count), 2);

    // Stuck B: fault at edge 24, drops with level 5 edges after release.
    sensor_b_raw = 1'b1;
    step(24);
    chk("stuck edge23 fault_b", int'(fault_b), 0);
    step(1);
    chk("stuck edge24 fault_b", int'(fault_b), 1);
    step(15);
    sensor_b_raw = 1'b0;
    step(5);
    chk("release edge4 sensor_b", int'(sensor_b), 1);
    chk("release edge4 fault_b", int'(fault_b), 1);
    step(1);
    chk("release edge5 sensor_b", int'(sensor_b), 0);
    chk("release edge5 fault_b", int'(fault_b), 0);

    // Simultaneous glitches saturating the counter.
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(3);
    for (int i = 0; i < 130; i++) begin
      sensor_a_raw = 1'b1;
      sensor_b_raw = 1'b1;
      step(3);
      sensor_a_raw = 1'b0;
      sensor_b_raw = 1'b0;
      step(3);
      if (i == 0)   chk("sim first glitch_count", int'(glitch_count), 2);
      if (i == 126) chk("sim 127 glitch_count", int'(glitch_count), 254);
      if (i == 127) chk("sim 128 glitch_count", int'(glitch_count), 255);
    end
    step(4);
    chk("sim final glitch_count", int'(glitch_count), 255);

    // Reset during CONFIRM_HIGH at cnt=3, full latency afterwards.
    sensor_a_raw = 1'b1;
    step(5);
    rst = 1'b1;
    step(1);
    chk("midrst a_rise", int'(a_rise), 0);
    chk("midrst sensor_a", int'(sensor_a), 0);
    rst = 1'b0;
    step(5);
    chk("midrst edge10 sensor_a", int'(sensor_a), 0);
    step(1);
    chk("midrst edge11 sensor_a", int'(sensor_a), 1);
    chk("midrst edge11 a_rise", int'(a_rise), 1);
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
